lpc_io_target: RTL and testbench

- LPC bus I/O-cycle target FSM that sits directly upstream of the CPLD register file.
- Decodes host I/O read/write cycles on LFRAME_N/LAD into single-cycle Addr/Wr/Rd/DataWrSW strobes.
- Returns register read data (RdData, the register file's DataReg[Addr] mux) on LAD with SYNC and turnaround.
- Claims a 32-byte I/O window; all other cycles are ignored, with LAD left undriven.

---
 rtl/lpc_pkg.sv | 33 +++
 rtl/lpc_io_target.sv | 150 +++++++++++++++
 tb/tb_lpc_io_target.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC I/O target definitions.
// Holds the FSM state type, cycle-type codes, SYNC/TAR nibbles and window width.
package lpc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CYCTYPE,
    ADDR3,
    ADDR2,
    ADDR1,
    ADDR0,
    WDATA0,
    WDATA1,
    HTAR0,
    HTAR1,
    SYNC,
    RDATA0,
    RDATA1,
    PTAR0,
    PTAR1,
    IGNORE
  } lpc_state_t;

  localparam logic [2:0] CYC_IO_RD = 3'b000;
  localparam logic [2:0] CYC_IO_WR = 3'b001;

  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_LWAIT = 4'h6;
  localparam logic [3:0] LAD_TAR    = 4'hF;

  localparam int IO_WIN_BITS = 5;

endpackage

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes a 32-byte I/O window into Addr/Wr/Rd strobes.
// Ports: LpcClock, PciReset (async low), LFRAME_N, LAD_in/out/oe, RdData, Addr, Wr, Rd, DataWrSW.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0800,
  parameter int          SYNC_WAIT = 0
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LFRAME_N,
  input  logic [3:0] LAD_in,
  output logic [3:0] LAD_out,
  output logic       LAD_oe,
  input  logic [7:0] RdData,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic       Rd,
  output logic [7:0] DataWrSW
);

  localparam logic [3:0] WAIT_INIT = 4'(SYNC_WAIT);

  lpc_state_t  state;
  logic [11:0] addr;
  logic [15:0] nxt_addr;
  logic        hit;
  logic        is_wr;
  logic [3:0]  wcnt;
  logic [7:0]  hold;

  // The last address nibble completes the decode in the same edge.
  always_comb begin
    nxt_addr = {addr, LAD_in};
    hit = (nxt_addr[15:IO_WIN_BITS] == BASE_ADDR[15:IO_WIN_BITS]);
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state    <= IDLE;
      addr     <= '0;
      is_wr    <= 1'b0;
      wcnt     <= '0;
      hold     <= '0;
      LAD_out  <= LAD_TAR;
      LAD_oe   <= 1'b0;
      Addr     <= '0;
      Wr       <= 1'b0;
      Rd       <= 1'b0;
      DataWrSW <= '0;
    end else begin
      Wr <= 1'b0;
      Rd <= 1'b0;
      if (!LFRAME_N) begin
        // START or abort: release the bus; a zero nibble opens a new frame.
        state   <= (LAD_in == 4'h0) ? CYCTYPE : IGNORE;
        LAD_oe  <= 1'b0;
        LAD_out <= LAD_TAR;
      end else begin
        unique case (state)
          IDLE: ;
          CYCTYPE: begin
            if (LAD_in[3:1] == CYC_IO_RD) begin
              is_wr <= 1'b0;
              state <= ADDR3;
            end else if (LAD_in[3:1] == CYC_IO_WR) begin
              is_wr <= 1'b1;
              state <= ADDR3;
            end else begin
              state <= IGNORE;
            end
          end
          ADDR3: begin
            addr  <= nxt_addr[11:0];
            state <= ADDR2;
          end
          ADDR2: begin
            addr  <= nxt_addr[11:0];
            state <= ADDR1;
          end
          ADDR1: begin
            addr  <= nxt_addr[11:0];
            state <= ADDR0;
          end
          ADDR0: begin
            if (hit) begin
              Addr  <= 8'(nxt_addr[IO_WIN_BITS-1:0]);
              state <= is_wr ? WDATA0 : HTAR0;
            end else begin
              state <= IGNORE;
            end
          end
          WDATA0: begin
            DataWrSW[3:0] <= LAD_in;
            state         <= WDATA1;
          end
          WDATA1: begin
            DataWrSW[7:4] <= LAD_in;
            state         <= HTAR0;
          end
          HTAR0: begin
            Rd    <= !is_wr;
            state <= HTAR1;
          end
          HTAR1: begin
            // Capture before the read-clear side effect lands.
            hold   <= RdData;
            state  <= SYNC;
            LAD_oe <= 1'b1;
            wcnt   <= WAIT_INIT;
            if (WAIT_INIT == 4'd0) begin
              LAD_out <= SYNC_READY;
              Wr      <= is_wr;
            end else begin
              LAD_out <= SYNC_LWAIT;
            end
          end
          SYNC: begin
            if (wcnt == 4'd0) begin
              state   <= is_wr ? PTAR0 : RDATA0;
              LAD_out <= is_wr ? LAD_TAR : hold[3:0];
            end else begin
              wcnt <= wcnt - 4'd1;
              if (wcnt == 4'd1) begin
                LAD_out <= SYNC_READY;
                Wr      <= is_wr;
              end
            end
          end
          RDATA0: begin
            LAD_out <= hold[7:4];
            state   <= RDATA1;
          end
          RDATA1: begin
            LAD_out <= LAD_TAR;
            state   <= PTAR0;
          end
          PTAR0: begin
            LAD_oe <= 1'b0;
            state  <= PTAR1;
          end
          PTAR1: state <= IDLE;
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_io_target.sv
// Bench for lpc_io_target: scoreboarded strobes and LAD nibbles.
// Second instance runs with two long-wait SYNC nibbles.
module tb_lpc_io_target;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } stb_t;

  logic       LpcClock;
  logic       PciReset;
  logic       frame1, frame2;
  logic [3:0] lad1_in, lad2_in;
  logic [7:0] RdData;

  logic [3:0] lad1_out, lad2_out;
  logic       oe1, oe2;
  logic [7:0] addr1, addr2;
  logic       wr1, wr2, rd1, rd2;
  logic [7:0] dw1, dw2;

  int total = 0;
  int bad = 0;
  logic sel2 = 1'b0;

  stb_t       sq1[$], sq2[$];
  logic [4:0] lq1[$], lq2[$];

  lpc_io_target #(.BASE_ADDR(16'h0800), .SYNC_WAIT(0)) dut (
    .LpcClock(LpcClock), .PciReset(PciReset),
    .LFRAME_N(frame1), .LAD_in(lad1_in),
    .LAD_out(lad1_out), .LAD_oe(oe1),
    .RdData(RdData), .Addr(addr1),
    .Wr(wr1), .Rd(rd1), .DataWrSW(dw1)
  );

  lpc_io_target #(.BASE_ADDR(16'h0800), .SYNC_WAIT(2)) dut2 (
    .LpcClock(LpcClock), .PciReset(PciReset),
    .LFRAME_N(frame2), .LAD_in(lad2_in),
    .LAD_out(lad2_out), .LAD_oe(oe2),
    .RdData(RdData), .Addr(addr2),
    .Wr(wr2), .Rd(rd2), .DataWrSW(dw2)
  );

  initial LpcClock = 1'b0;
  always #15 LpcClock = ~LpcClock;

  // Monitor, instance 1.
  always @(negedge LpcClock) begin
    stb_t e;
    logic [4:0] n;
    if (PciReset) begin
      if (wr1 || rd1) begin
        total++;
        if (sq1.size() == 0) begin
          bad++;
          $display("FAIL strobe1: unexpected wr=%0b rd=%0b addr=%h", wr1, rd1, addr1);
        end else begin
          e = sq1.pop_front();
          if (wr1 === rd1 || wr1 !== e.wr || addr1 !== e.addr ||
              (e.wr && dw1 !== e.data)) begin
            bad++;
            $display("FAIL strobe1: got wr=%0b rd=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                     wr1, rd1, addr1, dw1, e.wr, e.addr, e.data);
          end
        end
      end
      if (oe1) begin
        total++;
        if (lq1.size() == 0) begin
          bad++;
          $display("FAIL lad1: unexpected drive %h wr=%0b", lad1_out, wr1);
        end else begin
          n = lq1.pop_front();
          if ({wr1, lad1_out} !== n) begin
            bad++;
            $display("FAIL lad1: got wr=%0b lad=%h want wr=%0b lad=%h",
                     wr1, lad1_out, n[4], n[3:0]);
          end
        end
      end
    end
  end

  // Monitor, instance 2.
  always @(negedge LpcClock) begin
    stb_t e;
    logic [4:0] n;
    if (PciReset) begin
      if (wr2 || rd2) begin
        total++;
        if (sq2.size() == 0) begin
          bad++;
          $display("FAIL strobe2: unexpected wr=%0b rd=%0b addr=%h", wr2, rd2, addr2);
        end else begin
          e = sq2.pop_front();
          if (wr2 === rd2 || wr2 !== e.wr || addr2 !== e.addr ||
              (e.wr && dw2 !== e.data)) begin
            bad++;
            $display("FAIL strobe2: got wr=%0b rd=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                     wr2, rd2, addr2, dw2, e.wr, e.addr, e.data);
          end
        end
      end
      if (oe2) begin
        total++;
        if (lq2.size() == 0) begin
          bad++;
          $display("FAIL lad2: unexpected drive %h wr=%0b", lad2_out, wr2);
        end else begin
          n = lq2.pop_front();
          if ({wr2, lad2_out} !== n) begin
            bad++;
            $display("FAIL lad2: got wr=%0b lad=%h want wr=%0b lad=%h",
                     wr2, lad2_out, n[4], n[3:0]);
          end
        end
      end
    end
  end

  task automatic step(input logic f, input logic [3:0] l);
    if (sel2) begin
      frame2 = f;
      lad2_in = l;
    end else begin
      frame1 = f;
      lad1_in = l;
    end
    @(posedge LpcClock);
    #1;
  endtask

  task automatic write_cycle(input logic [15:0] a, input logic [7:0] d);
    int w;
    stb_t s;
    w = sel2 ? 2 : 0;
    s = '{wr: 1'b1, addr: {3'b000, a[4:0]}, data: d};
    if (sel2) begin
      sq2.push_back(s);
      for (int i = 0; i < w; i++) lq2.push_back({1'b0, 4'h6});
      lq2.push_back({1'b1, 4'h0});
      lq2.push_back({1'b0, 4'hF});
    end else begin
      sq1.push_back(s);
      lq1.push_back({1'b1, 4'h0});
      lq1.push_back({1'b0, 4'hF});
    end
    step(1'b0, 4'h0);
    step(1'b1, 4'h2);
    step(1'b1, a[15:12]);
    step(1'b1, a[11:8]);
    step(1'b1, a[7:4]);
    step(1'b1, a[3:0]);
    step(1'b1, d[3:0]);
    step(1'b1, d[7:4]);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    repeat (w + 3) step(1'b1, 4'hF);
    total++;
    if ((sel2 ? oe2 : oe1) !== 1'b0 ||
        (sel2 ? lq2.size() : lq1.size()) != 0) begin
      bad++;
      $display("FAIL write_end %h: oe1=%0b oe2=%0b lq1=%0d lq2=%0d want oe=0 queue=0",
               a, oe1, oe2, lq1.size(), lq2.size());
    end
  endtask

  task automatic read_cycle(input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] d_after);
    RdData = d;
    sq1.push_back('{wr: 1'b0, addr: {3'b000, a[4:0]}, data: 8'h00});
    lq1.push_back({1'b0, 4'h0});
    lq1.push_back({1'b0, d[3:0]});
    lq1.push_back({1'b0, d[7:4]});
    lq1.push_back({1'b0, 4'hF});
    step(1'b0, 4'h0);
    step(1'b1, 4'h0);
    step(1'b1, a[15:12]);
    step(1'b1, a[11:8]);
    step(1'b1, a[7:4]);
    step(1'b1, a[3:0]);
    step(1'b1, 4'hF);
    total++;
    if (rd1 !== 1'b1 || addr1 !== {3'b000, a[4:0]}) begin
      bad++;
      $display("FAIL rd_pulse %h: rd=%0b addr=%h want rd=1 addr=%h",
               a, rd1, addr1, {3'b000, a[4:0]});
    end
    step(1'b1, 4'hF);
    RdData = d_after;
    total++;
    if (rd1 !== 1'b0 || oe1 !== 1'b1) begin
      bad++;
      $display("FAIL rd_sync %h: rd=%0b oe=%0b want rd=0 oe=1", a, rd1, oe1);
    end
    repeat (5) step(1'b1, 4'hF);
    total++;
    if (oe1 !== 1'b0 || lq1.size() != 0 || sq1.size() != 0) begin
      bad++;
      $display("FAIL read_end %h: oe=%0b lq=%0d sq=%0d want 0 0 0",
               a, oe1, lq1.size(), sq1.size());
    end
  endtask

  task automatic miss_frame(input logic [3:0] cyc, input logic [15:0] a);
    logic [3:0] nib[12];
    logic seen;
    nib = '{cyc, a[15:12], a[11:8], a[7:4], a[3:0], 4'h5, 4'hA,
            4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    seen = 1'b0;
    step(1'b0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, nib[i]);
      seen = seen | oe1 | wr1 | rd1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL miss cyc=%h addr=%h: activity=%0b want 0", cyc, a, seen);
    end
  endtask

  task automatic test_reset();
    PciReset = 1'b0;
    frame1 = 1'b1;
    frame2 = 1'b1;
    lad1_in = 4'hF;
    lad2_in = 4'hF;
    RdData = 8'h00;
    repeat (3) step(1'b1, 4'hF);
    total++;
    if ({lad1_out, oe1, addr1, wr1, rd1, dw1} !== {4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset1: lad=%h oe=%0b addr=%h wr=%0b rd=%0b dw=%h",
               lad1_out, oe1, addr1, wr1, rd1, dw1);
    end
    total++;
    if ({lad2_out, oe2, addr2, wr2, rd2, dw2} !== {4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset2: lad=%h oe=%0b addr=%h wr=%0b rd=%0b dw=%h",
               lad2_out, oe2, addr2, wr2, rd2, dw2);
    end
    PciReset = 1'b1;
    repeat (2) step(1'b1, 4'hF);
  endtask

  task automatic test_write();
    write_cycle(16'h080B, 8'h5A);
    write_cycle(16'h081F, 8'hC3);
  endtask

  task automatic test_read();
    read_cycle(16'h0800, 8'h1A, 8'h1A);
  endtask

  task automatic test_read_clear();
    read_cycle(16'h080B, 8'hE0, 8'hA0);
  endtask

  task automatic test_sync_wait();
    sel2 = 1'b1;
    write_cycle(16'h0801, 8'h96);
    sel2 = 1'b0;
  endtask

  task automatic test_ignore();
    miss_frame(4'h2, 16'h0900);
    read_cycle(16'h0812, 8'h77, 8'h77);
    miss_frame(4'h4, 16'h0803);
    write_cycle(16'h0803, 8'h3C);
  endtask

  task automatic test_abort();
    step(1'b0, 4'h0);
    step(1'b1, 4'h2);
    step(1'b1, 4'h0);
    step(1'b1, 4'h8);
    read_cycle(16'h0804, 8'h4B, 8'h4B);
  endtask

  task automatic test_reset_mid();
    RdData = 8'h3C;
    sq1.push_back('{wr: 1'b0, addr: 8'h05, data: 8'h00});
    lq1.push_back({1'b0, 4'h0});
    step(1'b0, 4'h0);
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
    step(1'b1, 4'h8);
    step(1'b1, 4'h0);
    step(1'b1, 4'h5);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    total++;
    if (oe1 !== 1'b1 || lad1_out !== 4'hC) begin
      bad++;
      $display("FAIL rdata0: oe=%0b lad=%h want oe=1 lad=c", oe1, lad1_out);
    end
    PciReset = 1'b0;
    #1;
    total++;
    if ({lad1_out, oe1, addr1, wr1, rd1, dw1} !== {4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_mid: lad=%h oe=%0b addr=%h wr=%0b rd=%0b dw=%h",
               lad1_out, oe1, addr1, wr1, rd1, dw1);
    end
    repeat (2) step(1'b1, 4'hF);
    PciReset = 1'b1;
    repeat (2) step(1'b1, 4'hF);
    total++;
    if (oe1 !== 1'b0 || lq1.size() != 0 || sq1.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_end: oe=%0b lq=%0d sq=%0d want 0 0 0",
               oe1, lq1.size(), sq1.size());
    end
    read_cycle(16'h0806, 8'h81, 8'h81);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_clear();
    test_sync_wait();
    test_ignore();
    test_abort();
    test_reset_mid();
    repeat (3) step(1'b1, 4'hF);
    total++;
    if (sq1.size() + sq2.size() + lq1.size() + lq2.size() != 0) begin
      bad++;
      $display("FAIL leftover: sq1=%0d sq2=%0d lq1=%0d lq2=%0d want all 0",
               sq1.size(), sq2.size(), lq1.size(), lq2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
